// File: rtl/tlb_wb_sequencer_if.sv
// Write-buffer / memory-port bundle for tlb_wb_sequencer.
// master = the sequencer, slave = buffer + memory + refill environment.
interface tlb_wb_sequencer_if #(
   parameter int ADDR_WIDTH = 64,
   parameter int DATA_WIDTH = 64,
   parameter int BANK_NUM   = 4
);
   localparam int IDX_W = $clog2(BANK_NUM) - 1;

   logic                    busy_wb;
   logic [ADDR_WIDTH-1:0]   addr_mem;
   logic [2*DATA_WIDTH-1:0] data_mem;
   logic [IDX_W-1:0]        bank_index;
   logic                    finish_wb;
   logic                    mem_req;
   logic [ADDR_WIDTH-1:0]   mem_addr;
   logic [2*DATA_WIDTH-1:0] mem_wdata;
   logic                    mem_ack;
   logic                    refill_req;
   logic                    refill_grant;

   modport master (
      input  busy_wb, addr_mem, data_mem, mem_ack, refill_req,
      output bank_index, finish_wb, mem_req, mem_addr, mem_wdata, refill_grant
   );

   modport slave (
      output busy_wb, addr_mem, data_mem, mem_ack, refill_req,
      input  bank_index, finish_wb, mem_req, mem_addr, mem_wdata, refill_grant
   );
endinterface

// File: rtl/tlb_wb_sequencer.sv
// Drains an evicted TLB write-buffer line to memory in BANK_NUM/2 double-width beats.
// Optional ack-wait timeout with sticky wb_error: define WB_TIMEOUT_EN.
module tlb_wb_sequencer #(
   parameter int ADDR_WIDTH     = 64,
   parameter int DATA_WIDTH     = 64,
   parameter int BANK_NUM       = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                clk,
   input  logic                rstn,
   tlb_wb_sequencer_if.master  bus,
   output logic                wb_active,
   output logic                wb_error
);
   localparam int                    BEATS      = BANK_NUM / 2;
   localparam int                    IDX_W      = $clog2(BANK_NUM) - 1;
   localparam logic [IDX_W-1:0]      LAST_BEAT  = IDX_W'(BEATS - 1);
   localparam logic [ADDR_WIDTH-1:0] BEAT_BYTES = ADDR_WIDTH'(2 * DATA_WIDTH / 8);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   state_t           state_r;
   logic [IDX_W-1:0] beat_r;
   logic             mem_req_r;
   logic             finish_r;
   logic             active_r;
   logic             timeout_s;

`ifdef WB_TIMEOUT_EN
   localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [TO_W-1:0] to_cnt_r;
   logic            wb_error_r;

   assign timeout_s = (state_r == ST_WRITE) & ~bus.mem_ack &
                      (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));

   // Unacked-cycle counter for the current beat and the sticky timeout flag.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         to_cnt_r   <= '0;
         wb_error_r <= 1'b0;
      end else begin
         if ((state_r != ST_WRITE) || bus.mem_ack || timeout_s) begin
            to_cnt_r <= '0;
         end else begin
            to_cnt_r <= to_cnt_r + TO_W'(1);
         end
         if (timeout_s) begin
            wb_error_r <= 1'b1;
         end
      end
   end

   assign wb_error = wb_error_r;
`else
   assign timeout_s = 1'b0;
   assign wb_error  = 1'b0;
`endif

   // Writeback sequencer: state, beat number and all registered status outputs.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_r   <= ST_IDLE;
         beat_r    <= '0;
         mem_req_r <= 1'b0;
         finish_r  <= 1'b0;
         active_r  <= 1'b0;
      end else begin
         case (state_r)
            ST_IDLE: begin
               beat_r   <= '0;
               finish_r <= 1'b0;
               if (bus.busy_wb) begin
                  state_r   <= ST_WRITE;
                  mem_req_r <= 1'b1;
                  active_r  <= 1'b1;
               end else begin
                  mem_req_r <= 1'b0;
                  active_r  <= 1'b0;
               end
            end
            ST_WRITE: begin
               if (bus.mem_ack) begin
                  if (beat_r == LAST_BEAT) begin
                     state_r   <= ST_DONE;
                     mem_req_r <= 1'b0;
                     finish_r  <= 1'b1;
                  end else begin
                     beat_r <= beat_r + IDX_W'(1);
                  end
               end else if (timeout_s) begin
                  // Give up on this line but still release the buffer.
                  state_r   <= ST_DONE;
                  mem_req_r <= 1'b0;
                  finish_r  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_r   <= ST_IDLE;
               beat_r    <= '0;
               mem_req_r <= 1'b0;
               finish_r  <= 1'b0;
               active_r  <= 1'b0;
            end
            default: begin
               state_r   <= ST_IDLE;
               beat_r    <= '0;
               mem_req_r <= 1'b0;
               finish_r  <= 1'b0;
               active_r  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bank_index   = beat_r;
   assign bus.finish_wb    = finish_r;
   assign bus.mem_req      = mem_req_r;
   assign bus.mem_addr     = bus.addr_mem + (ADDR_WIDTH'(beat_r) * BEAT_BYTES);
   assign bus.mem_wdata    = bus.data_mem;
   // The port goes to refill only when no writeback is running or pending.
   assign bus.refill_grant = bus.refill_req & (state_r == ST_IDLE) & ~bus.busy_wb;
   assign wb_active        = active_r;

endmodule

// File: tb/tb_tlb_wb_sequencer.sv
// Self-checking bench for tlb_wb_sequencer: directed line drains plus randomized
// ack delays, bases, refill requests and back-to-back reloads against a beat-list model.
module tb_tlb_wb_sequencer;
   localparam int AW    = 64;
   localparam int DW    = 64;
   localparam int BN    = 4;
   localparam int TO    = 8;
   localparam int BEATS = BN / 2;

   logic clk = 1'b0;
   logic rstn;
   logic wb_active;
   logic wb_error;
   int   n_cmp = 0;
   int   n_err = 0;
   bit   exp_err = 1'b0;
   logic [DW-1:0] line_q [BN];

   always #5 clk = ~clk;

   tlb_wb_sequencer_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN)) bus ();

   tlb_wb_sequencer #(
      .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BANK_NUM(BN), .TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rstn(rstn), .bus(bus), .wb_active(wb_active), .wb_error(wb_error)
   );

   // Write buffer: presents the beat selected by bank_index.
   assign bus.data_mem = {line_q[2*bus.bank_index+1], line_q[2*bus.bank_index]};

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Inputs are already driven; sample at the falling edge, then step past the next rising edge.
   task automatic check_cycle(input string tag, input bit req, input int idx, input bit fin,
                              input bit act, input bit grant, input logic [63:0] addr,
                              input logic [127:0] wdata);
      @(negedge clk);
      chk({tag, ".mem_req"},      bus.mem_req,      req);
      chk({tag, ".bank_index"},   bus.bank_index,   idx);
      chk({tag, ".finish_wb"},    bus.finish_wb,    fin);
      chk({tag, ".wb_active"},    wb_active,        act);
      chk({tag, ".refill_grant"}, bus.refill_grant, grant);
      chk({tag, ".wb_error"},     wb_error,         exp_err);
      if (req) begin
         chk({tag, ".mem_addr"},  bus.mem_addr,  addr);
         chk({tag, ".mem_wdata"}, bus.mem_wdata, wdata);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic idle_cycle();
      bus.busy_wb    = 1'b0;
      bus.mem_ack    = 1'($urandom);
      bus.refill_req = 1'($urandom);
      check_cycle("idle", 1'b0, 0, 1'b0, 1'b0, bus.refill_req, 64'd0, 128'd0);
   endtask

   // One line drain: expected beat k writes {bank 2k+1, bank 2k} to base + 16k.
   task automatic do_line(input logic [63:0] base, input int fixed_dly, input bit reload);
      int d;
      for (int b = 0; b < BN; b++) line_q[b] = {$urandom, $urandom};
      bus.busy_wb    = 1'b1;
      bus.addr_mem   = base;
      bus.mem_ack    = 1'($urandom);
      bus.refill_req = 1'($urandom);
      check_cycle("start", 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 128'd0);
      for (int k = 0; k < BEATS; k++) begin
         d = (fixed_dly >= 0) ? fixed_dly : int'($urandom_range(3, 0));
         for (int w = 0; w <= d; w++) begin
            bus.mem_ack    = (w == d);
            bus.refill_req = 1'($urandom);
            check_cycle("beat", 1'b1, k, 1'b0, 1'b1, 1'b0, base + 64'(k * 16),
                        {line_q[2*k+1], line_q[2*k]});
         end
      end
      bus.mem_ack    = 1'($urandom);
      bus.refill_req = 1'($urandom);
      check_cycle("done", 1'b0, BEATS - 1, 1'b1, 1'b1, 1'b0, 64'd0, 128'd0);
      if (!reload) bus.busy_wb = 1'b0;
   endtask

   initial begin
      bit prev_reload;
      bit r;

      rstn           = 1'b0;
      bus.busy_wb    = 1'b0;
      bus.addr_mem   = '0;
      bus.mem_ack    = 1'b0;
      bus.refill_req = 1'b0;
      for (int b = 0; b < BN; b++) line_q[b] = '0;
      @(posedge clk);
      #1;
      check_cycle("reset", 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 128'd0);
      rstn = 1'b1;
      idle_cycle();

      // Ack tied high, then ack held low three cycles per beat, then address wrap.
      do_line(64'h1000, 0, 1'b0);
      idle_cycle();
      do_line(64'h1000, 3, 1'b0);
      idle_cycle();
      do_line(64'hFFFF_FFFF_FFFF_FFF0, 1, 1'b0);

      // Refill held high right after a drain: granted on the first free idle cycle.
      bus.busy_wb    = 1'b0;
      bus.refill_req = 1'b1;
      check_cycle("refill", 1'b0, 0, 1'b0, 1'b0, 1'b1, 64'd0, 128'd0);

      // Back-to-back reload on the finish edge.
      do_line(64'h2000, 0, 1'b1);
      do_line(64'h3000, 0, 1'b0);
      idle_cycle();

      // Reset during beat 1: no finish pulse afterwards.
      for (int b = 0; b < BN; b++) line_q[b] = {$urandom, $urandom};
      bus.busy_wb    = 1'b1;
      bus.addr_mem   = 64'h4000;
      bus.mem_ack    = 1'b1;
      bus.refill_req = 1'b0;
      check_cycle("rst.start", 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 128'd0);
      check_cycle("rst.beat0", 1'b1, 0, 1'b0, 1'b1, 1'b0, 64'h4000, {line_q[1], line_q[0]});
      rstn        = 1'b0;
      bus.mem_ack = 1'b0;
      check_cycle("rst.beat1", 1'b1, 1, 1'b0, 1'b1, 1'b0, 64'h4010, {line_q[3], line_q[2]});
      bus.busy_wb = 1'b0;
      check_cycle("rst.held", 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 128'd0);
      rstn = 1'b1;
      for (int i = 0; i < 3; i++) idle_cycle();

      // Randomized drains with random bases, delays, idle gaps and reloads.
      prev_reload = 1'b0;
      for (int t = 0; t < 24; t++) begin
         if (!prev_reload) begin
            for (int n = 0; n < int'($urandom_range(2, 0)); n++) idle_cycle();
         end
         r = 1'($urandom);
         do_line({$urandom, $urandom}, -1, r);
         prev_reload = r;
      end
      do_line({$urandom, $urandom}, -1, 1'b0);
      idle_cycle();

`ifdef WB_TIMEOUT_EN
      // Ack never arrives: DONE after TO unacked cycles, sticky error until reset.
      for (int b = 0; b < BN; b++) line_q[b] = {$urandom, $urandom};
      bus.busy_wb    = 1'b1;
      bus.addr_mem   = 64'h5000;
      bus.mem_ack    = 1'b0;
      bus.refill_req = 1'b0;
      check_cycle("to.start", 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 128'd0);
      for (int i = 0; i < TO; i++) begin
         check_cycle("to.wait", 1'b1, 0, 1'b0, 1'b1, 1'b0, 64'h5000, {line_q[1], line_q[0]});
      end
      exp_err = 1'b1;
      check_cycle("to.done", 1'b0, 0, 1'b1, 1'b1, 1'b0, 64'd0, 128'd0);
      for (int i = 0; i < 3; i++) idle_cycle();
      rstn    = 1'b0;
      bus.refill_req = 1'b0;
      check_cycle("to.rst", 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 128'd0);
      exp_err = 1'b0;
      check_cycle("to.cleared", 1'b0, 0, 1'b0, 1'b0, 1'b0, 64'd0, 128'd0);
      rstn = 1'b1;
      idle_cycle();
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
